counter_updown_param: RTL

//   Parametrised up/down counter, successor to the 4-bit latch/decrement counter.

---
 rtl/counter_updown_param.sv | 99 +++++++++
 1 files changed

// File: rtl/counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_param
// Brief    : Parametrised up/down counter with load, wrap/saturate, zero/max
//            flags and a registered terminal-count pulse. Optional macro
//            AUTO_RELOAD_EN: a down step at zero reloads the last latched value.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_param #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned WRAP    = 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN,
  input  logic             latch,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             max,
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_RST  = RST_VAL[WIDTH-1:0];
  localparam logic             c_WRAP = (WRAP != 0);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reload <= c_RST;
    end else if (latch) begin
      r_reload <= IN;
    end
  end
`endif

  always_comb begin
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    if (latch) begin
      w_next_count = IN;
    end else if (dec && !inc) begin
      if (r_count == c_ZERO) begin
`ifdef AUTO_RELOAD_EN
        w_next_count = r_reload;
        w_next_tc    = 1'b1;
`else
        if (c_WRAP) begin
          w_next_count = c_MAX;
          w_next_tc    = 1'b1;
        end
`endif
      end else begin
        // Reaching zero from one is a terminal count in both modes.
        w_next_count = r_count - c_ONE;
        w_next_tc    = (r_count == c_ONE);
      end
    end else if (inc && !dec) begin
      if (r_count == c_MAX) begin
        if (c_WRAP) begin
          w_next_count = c_ZERO;
          w_next_tc    = 1'b1;
        end
      end else begin
        w_next_count = r_count + c_ONE;
        w_next_tc    = (r_count == (c_MAX - c_ONE));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= c_RST;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
    end
  end

  assign counter = r_count;
  assign zero    = (r_count == c_ZERO);
  assign max     = (r_count == c_MAX);
  assign tc      = r_tc;

endmodule
`default_nettype wire
